memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have no parameters; bus widths are fixed at 32-bit data/address and 5-bit register index.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, independent of clk.
REQ-004 mem_valid_i  in  1  instruction present in stage this cycle.
REQ-005 mem_memop_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
REQ-006 mem_wen_i / mem_waddr_i / mem_alu_i / mem_st_data_i / mem_pc_i  in  1/5/32/32/32  reg write enable, dest index, ALU result (effective address for memops), store source, PC.
REQ-007 flush_i  in  1  kill instruction in stage; wb_stall_i  in  1  writeback cannot accept.
REQ-008 data_req_o, data_wr_o  out  1,1  bus request, 1 = store; data_ben_o  out  4  byte enables; data_addr_o, data_wdata_o  out  32,32.
REQ-009 data_addr_ok_i, data_data_ok_i  in  1,1  address accepted / data returned; data_rdata_i  in  32.
REQ-010 stall_o  out  1  hold upstream stage.
REQ-011 wb_valid_o, wb_wen_o, wb_waddr_o, wb_wdata_o, wb_pc_o, wb_memop_o  out  1/1/5/32/32/4  registered MEM/WB outputs to writeback.
REQ-012 excp_adel_o, excp_ades_o  out  1,1  misaligned load/store (combinational); badvaddr_o  out  32  faulting address.

Function
REQ-013 FSM states: IDLE, REQ (request outstanding, awaiting addr_ok), WAIT (awaiting data_ok), DONE (load/store complete, WB stalled), DROP (flushed, awaiting data_ok to discard).
REQ-014 Non-memop, valid, no flush: no bus activity; WB register loads inputs at next edge unless wb_stall_i; latency 1.
REQ-015 Alignment: LH/LHU/SH fault if addr[0]=1; LW/SW fault if addr[1:0]!=0; LB/LBU/SB never fault.
REQ-016 Faulting memop: no data_req_o; excp_adel_o (loads) or excp_ades_o (stores) high same cycle, badvaddr_o = mem_alu_i; WB register loads with wb_wen_o=0.
REQ-017 Aligned memop in IDLE: data_req_o asserted combinationally same cycle, state -> REQ if addr_ok low, -> WAIT if addr_ok high.
REQ-018 data_req_o, data_wr_o, data_addr_o={addr[31:2],2'b00}, data_ben_o, data_wdata_o SHALL stay stable from first assertion until addr_ok sampled high; data_req_o low in WAIT, DONE, DROP.
REQ-019 Store lanes: SB ben=4'b0001<<addr[1:0], wdata={4{byte}}; SH ben=4'b0011 (addr[1]=0) or 4'b1100, wdata={2{half}}; SW ben=4'b1111.
REQ-020 Load lanes: byte selected by addr[1:0], half by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-021 data_data_ok_i is only honoured in WAIT/DROP; it never arrives in the same cycle as its addr_ok.
REQ-022 WAIT + data_ok + !wb_stall_i: WB register loads (wdata = extended load data, or mem_alu_i for stores) at that edge, state -> IDLE, stall_o low that cycle.
REQ-023 WAIT + data_ok + wb_stall_i: extended data captured in internal buffer, state -> DONE; DONE -> IDLE and WB register loads from buffer on first cycle wb_stall_i low.
REQ-024 stall_o = wb_stall_i | (aligned memop in IDLE) | REQ | (WAIT & !data_ok) | DONE | DROP.
REQ-025 flush_i in IDLE or REQ before addr_ok: request withdrawn same cycle, state IDLE, WB register loads bubble (wb_valid_o=0).
REQ-026 flush_i in WAIT (or flush same cycle as addr_ok): state -> DROP; data_ok in DROP discarded, -> IDLE; no register write produced.
REQ-027 flush_i in DONE: buffered result discarded, -> IDLE.
REQ-028 When wb_stall_i high and no completion pending, WB register holds all values.
REQ-029 Bubble (mem_valid_i=0 or flush) SHALL load wb_valid_o=0, wb_wen_o=0.

Reset
REQ-030 While rst=0: state IDLE, all WB register outputs 0, data_req_o 0, internal buffer 0; first request may issue on the first cycle after rst rises.
REQ-031 Reset mid-transaction abandons it; any data_ok arriving afterwards in IDLE is ignored.

Verification
REQ-032 LW addr 0x100, addr_ok cycle 0, data_ok cycle 2 rdata 0x8000_00FF -> stall_o high cycles 0-1, wb_wdata_o=0x8000_00FF after cycle-2 edge.
REQ-033 LB addr 0x103, rdata 0x80AA_BBCC -> wb_wdata_o=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-034 SH addr 0x202 data 0x1234_5678 -> data_ben_o=4'b1100, data_wdata_o=0x5678_5678, data_wr_o=1.
REQ-035 LW addr 0x101 -> excp_adel_o=1, badvaddr_o=0x101, no data_req_o, wb_wen_o=0.
REQ-036 LW in WAIT, flush_i pulse, data_ok 2 cycles later -> state DROP then IDLE, wb_valid_o stays 0.
REQ-037 data_ok with wb_stall_i high 3 cycles -> DONE held, WB outputs unchanged; loaded on wb_stall_i fall; rst=0 mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: issues load/store requests on a request/ack data bus,
// aligns and extends load data, and registers results into the MEM/WB pipeline register.
module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [3:0]  mem_memop_i,
    input  logic        mem_wen_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic [31:0] mem_alu_i,
    input  logic [31:0] mem_st_data_i,
    input  logic [31:0] mem_pc_i,
    input  logic        flush_i,
    input  logic        wb_stall_i,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [3:0]  data_ben_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic        wb_wen_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic [31:0] wb_pc_o,
    output logic [3:0]  wb_memop_o,
    output logic        excp_adel_o,
    output logic        excp_ades_o,
    output logic [31:0] badvaddr_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] buf_r, buf_nxt_s;
    logic        is_load_s, is_store_s, misalign_s, aligned_s, fault_s;
    logic [3:0]  ben_s;
    logic [31:0] st_wdata_s, ext_s, result_s;
    logic        req_s, stall_s;
    logic        wb_load_s, wb_valid_nxt_s, wb_wen_nxt_s;
    logic [31:0] wb_wdata_nxt_s;

    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Decode memop class, alignment fault and store lane placement
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        misalign_s = 1'b0;
        ben_s      = 4'b0000;
        st_wdata_s = mem_st_data_i;
        case (mem_memop_i)
            OP_LB, OP_LBU: begin
                is_load_s = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_load_s  = 1'b1;
                misalign_s = mem_alu_i[0];
            end
            OP_LW: begin
                is_load_s  = 1'b1;
                misalign_s = |mem_alu_i[1:0];
            end
            OP_SB: begin
                is_store_s = 1'b1;
                ben_s      = 4'b0001 << mem_alu_i[1:0];
                st_wdata_s = {4{mem_st_data_i[7:0]}};
            end
            OP_SH: begin
                is_store_s = 1'b1;
                misalign_s = mem_alu_i[0];
                ben_s      = mem_alu_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_s = {2{mem_st_data_i[15:0]}};
            end
            OP_SW: begin
                is_store_s = 1'b1;
                misalign_s = |mem_alu_i[1:0];
                ben_s      = 4'b1111;
            end
            default: begin
                is_load_s = 1'b0;
            end
        endcase
    end

    assign aligned_s = mem_valid_i & (is_load_s | is_store_s) & ~misalign_s;
    assign fault_s   = mem_valid_i & ~flush_i & misalign_s;
    assign ext_s     = load_extend(mem_memop_i, mem_alu_i[1:0], data_rdata_i);
    assign result_s  = is_load_s ? ext_s : mem_alu_i;

    // Bus request and stall terms; the upstream stage holds its inputs while stalled
    always_comb begin
        req_s   = 1'b0;
        stall_s = wb_stall_i;
        case (state_r)
            IDLE: begin
                req_s   = aligned_s & ~flush_i;
                stall_s = wb_stall_i | (aligned_s & ~flush_i);
            end
            REQ: begin
                req_s   = ~flush_i;
                stall_s = 1'b1;
            end
            WAIT: begin
                stall_s = wb_stall_i | ~data_data_ok_i;
            end
            DONE, DROP: begin
                stall_s = 1'b1;
            end
            default: begin
                req_s = 1'b0;
            end
        endcase
    end

    // Combinational outputs, forced quiet while reset is held
    always_comb begin
        data_req_o   = 1'b0;
        data_wr_o    = 1'b0;
        data_ben_o   = 4'b0000;
        data_addr_o  = 32'd0;
        data_wdata_o = 32'd0;
        stall_o      = 1'b0;
        excp_adel_o  = 1'b0;
        excp_ades_o  = 1'b0;
        badvaddr_o   = 32'd0;
        if (rst) begin
            data_req_o   = req_s;
            data_wr_o    = is_store_s;
            data_ben_o   = ben_s;
            data_addr_o  = {mem_alu_i[31:2], 2'b00};
            data_wdata_o = st_wdata_s;
            stall_o      = stall_s;
            excp_adel_o  = fault_s & is_load_s;
            excp_ades_o  = fault_s & is_store_s;
            badvaddr_o   = mem_alu_i;
        end else begin
            data_req_o = 1'b0;
        end
    end

    // Next state, result buffer and MEM/WB load decision; a bubble clears only valid/wen
    always_comb begin
        state_nxt_s    = state_r;
        buf_nxt_s      = buf_r;
        wb_load_s      = ~wb_stall_i;
        wb_valid_nxt_s = 1'b0;
        wb_wen_nxt_s   = 1'b0;
        wb_wdata_nxt_s = mem_alu_i;
        case (state_r)
            IDLE: begin
                if (mem_valid_i && !flush_i) begin
                    if (aligned_s) begin
                        state_nxt_s = data_addr_ok_i ? WAIT : REQ;
                    end else begin
                        wb_valid_nxt_s = 1'b1;
                        wb_wen_nxt_s   = mem_wen_i & ~(is_load_s | is_store_s);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (flush_i) begin
                    state_nxt_s = data_addr_ok_i ? DROP : IDLE;
                end else if (data_addr_ok_i) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_nxt_s = data_data_ok_i ? IDLE : DROP;
                end else if (data_data_ok_i && wb_stall_i) begin
                    buf_nxt_s   = result_s;
                    state_nxt_s = DONE;
                end else if (data_data_ok_i) begin
                    wb_valid_nxt_s = 1'b1;
                    wb_wen_nxt_s   = mem_wen_i & is_load_s;
                    wb_wdata_nxt_s = result_s;
                    state_nxt_s    = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                if (flush_i) begin
                    state_nxt_s = IDLE;
                end else if (!wb_stall_i) begin
                    wb_valid_nxt_s = 1'b1;
                    wb_wen_nxt_s   = mem_wen_i & is_load_s;
                    wb_wdata_nxt_s = buf_r;
                    state_nxt_s    = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            DROP: begin
                state_nxt_s = data_data_ok_i ? IDLE : DROP;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, buffer and MEM/WB pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            buf_r      <= 32'd0;
            wb_valid_o <= 1'b0;
            wb_wen_o   <= 1'b0;
            wb_waddr_o <= 5'd0;
            wb_wdata_o <= 32'd0;
            wb_pc_o    <= 32'd0;
            wb_memop_o <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            buf_r   <= buf_nxt_s;
            if (wb_load_s) begin
                wb_valid_o <= wb_valid_nxt_s;
                wb_wen_o   <= wb_wen_nxt_s;
                if (wb_valid_nxt_s) begin
                    wb_waddr_o <= mem_waddr_i;
                    wb_wdata_o <= wb_wdata_nxt_s;
                    wb_pc_o    <= mem_pc_i;
                    wb_memop_o <= mem_memop_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a vector table of single transactions plus
// hand-written sequences for bus wait states, flushes, writeback stalls and reset.
module tb_memory_stage;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, mem_wen_i, flush_i, wb_stall_i;
    logic [3:0]  mem_memop_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_alu_i, mem_st_data_i, mem_pc_i;
    logic        data_req_o, data_wr_o;
    logic [3:0]  data_ben_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_addr_ok_i, data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic        stall_o, wb_valid_o, wb_wen_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o, wb_pc_o;
    logic [3:0]  wb_memop_o;
    logic        excp_adel_o, excp_ades_o;
    logic [31:0] badvaddr_o;

    int errors = 0;
    int checks = 0;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_memop_i(mem_memop_i), .mem_wen_i(mem_wen_i),
        .mem_waddr_i(mem_waddr_i), .mem_alu_i(mem_alu_i), .mem_st_data_i(mem_st_data_i),
        .mem_pc_i(mem_pc_i), .flush_i(flush_i), .wb_stall_i(wb_stall_i),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_ben_o(data_ben_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
        .data_rdata_i(data_rdata_i), .stall_o(stall_o),
        .wb_valid_o(wb_valid_o), .wb_wen_o(wb_wen_o), .wb_waddr_o(wb_waddr_o),
        .wb_wdata_o(wb_wdata_o), .wb_pc_o(wb_pc_o), .wb_memop_o(wb_memop_o),
        .excp_adel_o(excp_adel_o), .excp_ades_o(excp_ades_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] addr, st, rdata;
        logic        wen, bus, lanes, wr;
        logic [3:0]  ben;
        logic [31:0] bwd;
        logic        stall, adel, ades, wbv, wbwen, wdchk;
        logic [31:0] wbd;
    } vec_t;

    function automatic vec_t mk(input logic valid, input logic [3:0] op,
                                input logic [31:0] addr, input logic [31:0] st,
                                input logic [31:0] rdata, input logic wen, input logic bus,
                                input logic lanes, input logic wr, input logic [3:0] ben,
                                input logic [31:0] bwd, input logic stall, input logic adel,
                                input logic ades, input logic wbv, input logic wbwen,
                                input logic wdchk, input logic [31:0] wbd);
        vec_t v;
        v.valid = valid; v.op = op; v.addr = addr; v.st = st; v.rdata = rdata;
        v.wen = wen; v.bus = bus; v.lanes = lanes; v.wr = wr; v.ben = ben; v.bwd = bwd;
        v.stall = stall; v.adel = adel; v.ades = ades;
        v.wbv = wbv; v.wbwen = wbwen; v.wdchk = wdchk; v.wbd = wbd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid_i = 1'b0; mem_memop_i = 4'd0; flush_i = 1'b0; wb_stall_i = 1'b0;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic wen);
        mem_valid_i = 1'b1; mem_memop_i = op; mem_alu_i = addr; mem_wen_i = wen;
        mem_st_data_i = 32'h0; mem_waddr_i = 5'd3; mem_pc_i = 32'h0000_2000;
    endtask

    vec_t vec[19];
    vec_t v;

    initial begin
        vec[0]  = mk(Y,4'd5,32'h100,32'h0,32'h800000FF,Y, Y,N,N,4'h0,32'h0, Y,N,N, Y,Y,Y,32'h800000FF);
        vec[1]  = mk(Y,4'd1,32'h103,32'h0,32'h80AABBCC,Y, Y,N,N,4'h0,32'h0, Y,N,N, Y,Y,Y,32'hFFFFFF80);
        vec[2]  = mk(Y,4'd2,32'h103,32'h0,32'h80AABBCC,Y, Y,N,N,4'h0,32'h0, Y,N,N, Y,Y,Y,32'h00000080);
        vec[3]  = mk(Y,4'd3,32'h102,32'h0,32'h80AABBCC,Y, Y,N,N,4'h0,32'h0, Y,N,N, Y,Y,Y,32'hFFFF80AA);
        vec[4]  = mk(Y,4'd4,32'h100,32'h0,32'h80AABBCC,Y, Y,N,N,4'h0,32'h0, Y,N,N, Y,Y,Y,32'h0000BBCC);
        vec[5]  = mk(Y,4'd1,32'h100,32'h0,32'h80AABBCC,Y, Y,N,N,4'h0,32'h0, Y,N,N, Y,Y,Y,32'hFFFFFFCC);
        vec[6]  = mk(Y,4'd1,32'h102,32'h0,32'h12345678,Y, Y,N,N,4'h0,32'h0, Y,N,N, Y,Y,Y,32'h00000034);
        vec[7]  = mk(Y,4'd7,32'h202,32'h12345678,32'h0,N, Y,Y,Y,4'hC,32'h56785678, Y,N,N, Y,N,Y,32'h00000202);
        vec[8]  = mk(Y,4'd6,32'h201,32'h000000AB,32'h0,N, Y,Y,Y,4'h2,32'hABABABAB, Y,N,N, Y,N,Y,32'h00000201);
        vec[9]  = mk(Y,4'd8,32'h204,32'hDEADBEEF,32'h0,N, Y,Y,Y,4'hF,32'hDEADBEEF, Y,N,N, Y,N,Y,32'h00000204);
        vec[10] = mk(Y,4'd7,32'h200,32'h0000CAFE,32'h0,N, Y,Y,Y,4'h3,32'hCAFECAFE, Y,N,N, Y,N,Y,32'h00000200);
        vec[11] = mk(Y,4'd5,32'h101,32'h0,32'h0,Y, N,N,N,4'h0,32'h0, N,Y,N, Y,N,N,32'h0);
        vec[12] = mk(Y,4'd3,32'h103,32'h0,32'h0,Y, N,N,N,4'h0,32'h0, N,Y,N, Y,N,N,32'h0);
        vec[13] = mk(Y,4'd7,32'h203,32'h0,32'h0,N, N,N,N,4'h0,32'h0, N,N,Y, Y,N,N,32'h0);
        vec[14] = mk(Y,4'd8,32'h206,32'h0,32'h0,N, N,N,N,4'h0,32'h0, N,N,Y, Y,N,N,32'h0);
        vec[15] = mk(Y,4'd6,32'h203,32'h00000011,32'h0,N, Y,Y,Y,4'h8,32'h11111111, Y,N,N, Y,N,Y,32'h00000203);
        vec[16] = mk(Y,4'd0,32'h12345678,32'h0,32'h0,Y, N,N,N,4'h0,32'h0, N,N,N, Y,Y,Y,32'h12345678);
        vec[17] = mk(Y,4'd12,32'hCAFE0000,32'h0,32'h0,Y, N,N,N,4'h0,32'h0, N,N,N, Y,Y,Y,32'hCAFE0000);
        vec[18] = mk(N,4'd5,32'h100,32'h0,32'h0,Y, N,N,N,4'h0,32'h0, N,N,N, N,N,N,32'h0);

        // Reset state
        rst = 1'b0;
        idle_inputs();
        mem_wen_i = 1'b0; mem_waddr_i = 5'd0; mem_alu_i = 32'h0; mem_st_data_i = 32'h0; mem_pc_i = 32'h0;
        #12;
        chk("rst_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("rst_wb_wdata", wb_wdata_o, 32'h0);
        chk("rst_wb_memop", 32'(wb_memop_o), 32'h0);
        chk("rst_req", 32'(data_req_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Table of single transactions: address accepted in cycle 0, data in cycle 1
        for (int i = 0; i < 19; i++) begin
            v = vec[i];
            mem_valid_i = v.valid; mem_memop_i = v.op; mem_alu_i = v.addr;
            mem_st_data_i = v.st; mem_wen_i = v.wen; mem_waddr_i = 5'(i + 1);
            mem_pc_i = 32'h1000 + 32'(i * 4);
            data_addr_ok_i = v.bus; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
            #3;
            chk($sformatf("v%0d_req", i), 32'(data_req_o), 32'(v.bus));
            chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(v.stall));
            chk($sformatf("v%0d_adel", i), 32'(excp_adel_o), 32'(v.adel));
            chk($sformatf("v%0d_ades", i), 32'(excp_ades_o), 32'(v.ades));
            if (v.bus) begin
                chk($sformatf("v%0d_addr", i), data_addr_o, v.addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d_wr", i), 32'(data_wr_o), 32'(v.wr));
            end
            if (v.lanes) begin
                chk($sformatf("v%0d_ben", i), 32'(data_ben_o), 32'(v.ben));
                chk($sformatf("v%0d_bwdata", i), data_wdata_o, v.bwd);
            end
            if (v.adel || v.ades) chk($sformatf("v%0d_badv", i), badvaddr_o, v.addr);
            tick();
            if (v.bus) begin
                data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = v.rdata;
                #3;
                chk($sformatf("v%0d_req_wait", i), 32'(data_req_o), 32'h0);
                chk($sformatf("v%0d_stall_dok", i), 32'(stall_o), 32'h0);
                tick();
                data_data_ok_i = 1'b0;
            end
            chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid_o), 32'(v.wbv));
            chk($sformatf("v%0d_wb_wen", i), 32'(wb_wen_o), 32'(v.wbwen));
            if (v.wbv) begin
                chk($sformatf("v%0d_wb_waddr", i), 32'(wb_waddr_o), 32'(i + 1));
                chk($sformatf("v%0d_wb_pc", i), wb_pc_o, 32'h1000 + 32'(i * 4));
                chk($sformatf("v%0d_wb_memop", i), 32'(wb_memop_o), 32'(v.op));
            end
            if (v.wdchk) chk($sformatf("v%0d_wb_wdata", i), wb_wdata_o, v.wbd);
            idle_inputs();
            tick();
        end

        // LW with addr_ok in cycle 0 and data_ok in cycle 2
        issue(4'd5, 32'h100, 1'b1); data_addr_ok_i = 1'b1;
        #3; chk("lw2_stall_c0", 32'(stall_o), 32'h1);
        tick(); data_addr_ok_i = 1'b0;
        #3; chk("lw2_stall_c1", 32'(stall_o), 32'h1);
        chk("lw2_req_c1", 32'(data_req_o), 32'h0);
        tick(); data_data_ok_i = 1'b1; data_rdata_i = 32'h8000_00FF;
        #3; chk("lw2_stall_c2", 32'(stall_o), 32'h0);
        tick(); data_data_ok_i = 1'b0;
        chk("lw2_wdata", wb_wdata_o, 32'h8000_00FF);
        chk("lw2_valid", 32'(wb_valid_o), 32'h1);
        idle_inputs(); tick();

        // Request held stable for two cycles before addr_ok
        issue(4'd5, 32'h104, 1'b1);
        #3; chk("hold_req_c0", 32'(data_req_o), 32'h1);
        tick();
        #3; chk("hold_req_c1", 32'(data_req_o), 32'h1);
        chk("hold_addr_c1", data_addr_o, 32'h104);
        chk("hold_stall_c1", 32'(stall_o), 32'h1);
        tick(); data_addr_ok_i = 1'b1;
        #3; chk("hold_req_c2", 32'(data_req_o), 32'h1);
        tick(); data_addr_ok_i = 1'b0;
        #3; chk("hold_req_wait", 32'(data_req_o), 32'h0);
        data_data_ok_i = 1'b1; data_rdata_i = 32'hA5A5_A5A5;
        tick(); data_data_ok_i = 1'b0;
        chk("hold_wdata", wb_wdata_o, 32'hA5A5_A5A5);
        idle_inputs(); tick();

        // Flush while the request is still waiting for addr_ok
        issue(4'd5, 32'h108, 1'b1);
        tick(); flush_i = 1'b1;
        #3; chk("freq_req", 32'(data_req_o), 32'h0);
        tick(); flush_i = 1'b0; mem_valid_i = 1'b0;
        chk("freq_wb_valid", 32'(wb_valid_o), 32'h0);
        #3; chk("freq_stall", 32'(stall_o), 32'h0);
        tick();

        // Flush in WAIT, data_ok arrives two cycles later and is discarded
        issue(4'd5, 32'h10C, 1'b1); data_addr_ok_i = 1'b1;
        tick(); data_addr_ok_i = 1'b0; flush_i = 1'b1;
        tick(); flush_i = 1'b0; mem_valid_i = 1'b0;
        chk("drop_wb_valid0", 32'(wb_valid_o), 32'h0);
        #3; chk("drop_stall0", 32'(stall_o), 32'h1);
        chk("drop_req0", 32'(data_req_o), 32'h0);
        tick(); data_data_ok_i = 1'b1; data_rdata_i = 32'hDEAD_0000;
        #3; chk("drop_stall1", 32'(stall_o), 32'h1);
        tick(); data_data_ok_i = 1'b0;
        chk("drop_wb_valid1", 32'(wb_valid_o), 32'h0);
        chk("drop_wb_wen1", 32'(wb_wen_o), 32'h0);
        #3; chk("drop_idle_stall", 32'(stall_o), 32'h0);
        tick();

        // Writeback stall: result parked in DONE, released when stall drops
        issue(4'd0, 32'h55AA_55AA, 1'b1);
        tick();
        chk("wbs_pre_wdata", wb_wdata_o, 32'h55AA_55AA);
        issue(4'd5, 32'h110, 1'b1); wb_stall_i = 1'b1; data_addr_ok_i = 1'b1;
        tick(); data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h1122_3344;
        #3; chk("wbs_stall_dok", 32'(stall_o), 32'h1);
        tick(); data_data_ok_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wbs_hold_wdata%0d", k), wb_wdata_o, 32'h55AA_55AA);
            chk($sformatf("wbs_hold_valid%0d", k), 32'(wb_valid_o), 32'h1);
            chk($sformatf("wbs_hold_stall%0d", k), 32'(stall_o), 32'h1);
            tick();
        end
        wb_stall_i = 1'b0;
        #3; chk("wbs_done_stall", 32'(stall_o), 32'h1);
        tick();
        chk("wbs_rel_wdata", wb_wdata_o, 32'h1122_3344);
        chk("wbs_rel_valid", 32'(wb_valid_o), 32'h1);
        chk("wbs_rel_wen", 32'(wb_wen_o), 32'h1);
        idle_inputs(); tick();

        // Reset asserted mid-WAIT clears everything at once
        issue(4'd5, 32'h114, 1'b1); data_addr_ok_i = 1'b1;
        tick(); data_addr_ok_i = 1'b0;
        #2; rst = 1'b0;
        #1;
        chk("mrst_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("mrst_wb_wdata", wb_wdata_o, 32'h0);
        chk("mrst_wb_pc", wb_pc_o, 32'h0);
        chk("mrst_req", 32'(data_req_o), 32'h0);
        chk("mrst_stall", 32'(stall_o), 32'h0);
        mem_valid_i = 1'b0;
        tick(); rst = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
        #3; chk("mrst_late_stall", 32'(stall_o), 32'h0);
        tick(); data_data_ok_i = 1'b0;
        chk("mrst_late_valid", 32'(wb_valid_o), 32'h0);
        issue(4'd5, 32'h118, 1'b1); data_addr_ok_i = 1'b1;
        #3; chk("mrst_new_req", 32'(data_req_o), 32'h1);
        tick(); data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h0BAD_F00D;
        tick(); data_data_ok_i = 1'b0;
        chk("mrst_new_wdata", wb_wdata_o, 32'h0BAD_F00D);
        idle_inputs(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
